satalnk_primrx: RTL and testbench



---
 rtl/satalnk_pkg.sv | 51 +++++
 rtl/satalnk_primdec.sv | 25 ++
 rtl/satalnk_primrx.sv | 134 +++++++++++++
 tb/tb_satalnk_primrx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/satalnk_pkg.sv
// Shared SATA link-layer constants: primitive dwords (K28.x byte first) and
// the compact primitive IDs used by the receive and transmit conditioners.
package satalnk_pkg;

    localparam logic [31:0] PRIM_ALIGN   = 32'hbc4a4a7b;
    localparam logic [31:0] PRIM_CONT    = 32'h7caa9999;
    localparam logic [31:0] PRIM_SYNC    = 32'h7c95b5b5;
    localparam logic [31:0] PRIM_X_RDY   = 32'h7cb55757;
    localparam logic [31:0] PRIM_R_RDY   = 32'h7c954a4a;
    localparam logic [31:0] PRIM_SOF     = 32'h7cb53737;
    localparam logic [31:0] PRIM_EOF     = 32'h7cb5d5d5;
    localparam logic [31:0] PRIM_HOLD    = 32'h7caad5d5;
    localparam logic [31:0] PRIM_HOLDA   = 32'h7caa9595;
    localparam logic [31:0] PRIM_R_IP    = 32'h7cb55555;
    localparam logic [31:0] PRIM_R_OK    = 32'h7cb53535;
    localparam logic [31:0] PRIM_R_ERR   = 32'h7cb55656;
    localparam logic [31:0] PRIM_WTRM    = 32'h7cb55858;
    localparam logic [31:0] PRIM_DMAT    = 32'h7cb53636;
    localparam logic [31:0] PRIM_PMREQ_P = 32'h7cb51717;
    localparam logic [31:0] PRIM_PMREQ_S = 32'h7c957575;
    localparam logic [31:0] PRIM_PMACK   = 32'h7c959595;
    localparam logic [31:0] PRIM_PMNAK   = 32'h7c95f5f5;

    localparam logic [4:0] ID_NONE    = 5'd0;
    localparam logic [4:0] ID_SYNC    = 5'd1;
    localparam logic [4:0] ID_X_RDY   = 5'd2;
    localparam logic [4:0] ID_R_RDY   = 5'd3;
    localparam logic [4:0] ID_SOF     = 5'd4;
    localparam logic [4:0] ID_EOF     = 5'd5;
    localparam logic [4:0] ID_HOLD    = 5'd6;
    localparam logic [4:0] ID_HOLDA   = 5'd7;
    localparam logic [4:0] ID_R_IP    = 5'd8;
    localparam logic [4:0] ID_R_OK    = 5'd9;
    localparam logic [4:0] ID_R_ERR   = 5'd10;
    localparam logic [4:0] ID_WTRM    = 5'd11;
    localparam logic [4:0] ID_DMAT    = 5'd12;
    localparam logic [4:0] ID_PMREQ_P = 5'd13;
    localparam logic [4:0] ID_PMREQ_S = 5'd14;
    localparam logic [4:0] ID_PMACK   = 5'd15;
    localparam logic [4:0] ID_PMNAK   = 5'd16;

    localparam int NUM_PRIMS = 16;

    // Entry i decodes to ID i+1, so the table order must track the IDs above.
    localparam logic [31:0] PRIM_WORDS [NUM_PRIMS] = '{
        PRIM_SYNC, PRIM_X_RDY, PRIM_R_RDY, PRIM_SOF, PRIM_EOF, PRIM_HOLD,
        PRIM_HOLDA, PRIM_R_IP, PRIM_R_OK, PRIM_R_ERR, PRIM_WTRM, PRIM_DMAT,
        PRIM_PMREQ_P, PRIM_PMREQ_S, PRIM_PMACK, PRIM_PMNAK
    };

endpackage

// File: rtl/satalnk_primdec.sv
// Combinational primitive decoder: 32-bit dword in, compact ID out (0 when the
// word matches no known primitive). Shared by the receive and transmit paths.
module satalnk_primdec
    import satalnk_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [4:0]  o_id
);

    logic [NUM_PRIMS-1:0] w_hit;

    generate
        for (genvar gi = 0; gi < NUM_PRIMS; gi++) begin : g_hit
            assign w_hit[gi] = (i_word == PRIM_WORDS[gi]);
        end
    endgenerate

    always_comb begin
        o_id = ID_NONE;
        for (int i = 0; i < NUM_PRIMS; i++) begin
            if (w_hit[i]) o_id = 5'(i + 1);
        end
    end

endmodule

// File: rtl/satalnk_primrx.sv
// Receive primitive conditioner: strips ALIGN, expands/collapses CONT runs,
// discards scrambled junk, decodes primitives and counts junk words.
module satalnk_primrx
    import satalnk_pkg::*;
#(
    parameter logic [32:0] P_CONT       = {1'b1, PRIM_CONT},
    parameter logic [32:0] P_ALIGN      = {1'b1, PRIM_ALIGN},
    parameter bit          OPT_DEDUP    = 1'b0,
    parameter bit          OPT_LOWPOWER = 1'b0,
    parameter int          LGCOUNT      = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic               i_primitive,
    input  logic [31:0]        i_data,
    input  logic               i_clr_count,
    output logic               o_valid,
    output logic               o_primitive,
    output logic [31:0]        o_data,
    output logic [4:0]         o_prim_id,
    output logic               o_err_orphan,
    output logic               o_err_unknown,
    output logic [LGCOUNT-1:0] o_junk_count
);

    localparam logic [LGCOUNT-1:0] CNT_MAX = '1;

    logic               r_active, r_have_last, r_emit_prim;
    logic [31:0]        r_last;
    logic               r_valid, r_primitive, r_err_orphan, r_err_unknown;
    logic [31:0]        r_data;
    logic [4:0]         r_prim_id;
    logic [LGCOUNT-1:0] r_junk_count;

    logic        w_is_align, w_is_cont, w_is_prim, w_is_data;
    logic        w_emit_v, w_emit_p, w_orphan, w_junk;
    logic [31:0] w_emit_d;
    logic        w_active_next, w_have_next, w_emit_prim_next;
    logic [4:0]  w_id;

    assign w_is_align = i_valid && ({i_primitive, i_data} == P_ALIGN);
    assign w_is_cont  = i_valid && ({i_primitive, i_data} == P_CONT);
    assign w_is_prim  = i_valid && i_primitive && !w_is_align && !w_is_cont;
    assign w_is_data  = i_valid && !i_primitive;

    // ALIGN and idle cycles fall through every branch: nothing emitted, state held.
    always_comb begin
        w_emit_v         = 1'b0;
        w_emit_p         = 1'b0;
        w_emit_d         = i_data;
        w_orphan         = 1'b0;
        w_junk           = 1'b0;
        w_active_next    = r_active;
        w_have_next      = r_have_last;
        w_emit_prim_next = r_emit_prim;
        if (w_is_cont) begin
            w_active_next = 1'b1;
            if (r_have_last) begin
                w_emit_p = 1'b1;
                w_emit_d = r_last;
                w_emit_v = !(OPT_DEDUP && r_emit_prim);
            end else begin
                w_orphan = 1'b1;
            end
        end else if (w_is_prim) begin
            w_active_next = 1'b0;
            w_have_next   = 1'b1;
            w_emit_p      = 1'b1;
            w_emit_v      = !(OPT_DEDUP && r_emit_prim && (i_data == r_last));
        end else if (w_is_data) begin
            if (r_active) begin
                w_junk = 1'b1;
                if (!OPT_DEDUP && r_have_last) begin
                    w_emit_v = 1'b1;
                    w_emit_p = 1'b1;
                    w_emit_d = r_last;
                end
            end else begin
                w_emit_v         = 1'b1;
                w_emit_prim_next = 1'b0;
            end
        end
        if (w_emit_v && w_emit_p) w_emit_prim_next = 1'b1;
    end

    satalnk_primdec u_dec (
        .i_word (w_emit_d),
        .o_id   (w_id)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_active      <= 1'b0;
            r_have_last   <= 1'b0;
            r_emit_prim   <= 1'b0;
            r_valid       <= 1'b0;
            r_primitive   <= 1'b0;
            r_data        <= '0;
            r_prim_id     <= ID_NONE;
            r_err_orphan  <= 1'b0;
            r_err_unknown <= 1'b0;
            r_junk_count  <= '0;
        end else begin
            r_active      <= w_active_next;
            r_have_last   <= w_have_next;
            r_emit_prim   <= w_emit_prim_next;
            r_valid       <= w_emit_v;
            r_primitive   <= w_emit_v && w_emit_p;
            r_data        <= (OPT_LOWPOWER && !w_emit_v) ? 32'd0 : w_emit_d;
            r_prim_id     <= ((OPT_LOWPOWER && !w_emit_v) || !w_emit_p) ? ID_NONE : w_id;
            r_err_orphan  <= w_orphan;
            r_err_unknown <= w_emit_v && w_emit_p && (w_id == ID_NONE);
            if (i_clr_count)
                r_junk_count <= '0;
            else if (w_junk && r_junk_count != CNT_MAX)
                r_junk_count <= r_junk_count + 1'b1;
        end
    end

    // The held primitive is only ever read behind r_have_last, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_is_prim) r_last <= i_data;
    end

    assign o_valid       = r_valid;
    assign o_primitive   = r_primitive;
    assign o_data        = r_data;
    assign o_prim_id     = r_prim_id;
    assign o_err_orphan  = r_err_orphan;
    assign o_err_unknown = r_err_unknown;
    assign o_junk_count  = r_junk_count;

endmodule

// File: tb/tb_satalnk_primrx.sv
// Directed bench for satalnk_primrx: three instances (expand, dedup+lowpower,
// 2-bit counter) share one stimulus stream; each step checks the relevant one.
module tb_satalnk_primrx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid, prim, clr;
    logic [31:0] data;

    logic        u0_valid, u0_prim, u0_orph, u0_unk;
    logic [31:0] u0_data;
    logic [4:0]  u0_id;
    logic [15:0] u0_cnt;
    logic        u1_valid, u1_prim, u1_orph, u1_unk;
    logic [31:0] u1_data;
    logic [4:0]  u1_id;
    logic [15:0] u1_cnt;
    logic        u2_valid, u2_prim, u2_orph, u2_unk;
    logic [31:0] u2_data;
    logic [4:0]  u2_id;
    logic [1:0]  u2_cnt;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] W_CONT  = 32'h7caa9999;
    localparam logic [31:0] W_ALIGN = 32'hbc4a4a7b;
    localparam logic [31:0] W_SYNC  = 32'h7c95b5b5;
    localparam logic [31:0] W_XRDY  = 32'h7cb55757;
    localparam logic [31:0] W_RRDY  = 32'h7c954a4a;
    localparam logic [31:0] W_HOLD  = 32'h7caad5d5;
    localparam logic [31:0] W_UNK   = 32'h7c95dead;

    always #5 clk = ~clk;

    satalnk_primrx #(.OPT_DEDUP(1'b0), .OPT_LOWPOWER(1'b0), .LGCOUNT(16)) u0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .i_primitive(prim),
        .i_data(data), .i_clr_count(clr), .o_valid(u0_valid), .o_primitive(u0_prim),
        .o_data(u0_data), .o_prim_id(u0_id), .o_err_orphan(u0_orph),
        .o_err_unknown(u0_unk), .o_junk_count(u0_cnt));

    satalnk_primrx #(.OPT_DEDUP(1'b1), .OPT_LOWPOWER(1'b1), .LGCOUNT(16)) u1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .i_primitive(prim),
        .i_data(data), .i_clr_count(clr), .o_valid(u1_valid), .o_primitive(u1_prim),
        .o_data(u1_data), .o_prim_id(u1_id), .o_err_orphan(u1_orph),
        .o_err_unknown(u1_unk), .o_junk_count(u1_cnt));

    satalnk_primrx #(.OPT_DEDUP(1'b0), .OPT_LOWPOWER(1'b0), .LGCOUNT(2)) u2 (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .i_primitive(prim),
        .i_data(data), .i_clr_count(clr), .o_valid(u2_valid), .o_primitive(u2_prim),
        .o_data(u2_data), .o_prim_id(u2_id), .o_err_orphan(u2_orph),
        .o_err_unknown(u2_unk), .o_junk_count(u2_cnt));

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word, let it be registered, then sample just after the edge.
    task automatic step(input logic v, input logic p, input logic [31:0] d, input logic c = 1'b0);
        valid = v;
        prim  = p;
        data  = d;
        clr   = c;
        @(posedge clk);
        #1;
        $display("step v=%0b p=%0b d=%h clr=%0b -> u0 v=%0b p=%0b d=%h id=%0d cnt=%0d | u1 v=%0b | u2 cnt=%0d",
                 v, p, d, c, u0_valid, u0_prim, u0_data, u0_id, u0_cnt, u1_valid, u2_cnt);
    endtask

    task automatic exp0(input string tag, input logic v, input logic p,
                        input logic [31:0] d, input logic [4:0] id);
        chk({tag, ".valid"}, 40'(u0_valid), 40'(v));
        if (v) begin
            chk({tag, ".prim"}, 40'(u0_prim), 40'(p));
            chk({tag, ".data"}, 40'(u0_data), 40'(d));
            chk({tag, ".id"},   40'(u0_id),   40'(id));
        end
    endtask

    task automatic exp_zero(input string tag);
        chk({tag, ".u0flags"}, 40'({u0_valid, u0_prim, u0_id, u0_orph, u0_unk}), 40'd0);
        chk({tag, ".u0data"},  40'(u0_data), 40'd0);
        chk({tag, ".u0cnt"},   40'(u0_cnt),  40'd0);
        chk({tag, ".u2cnt"},   40'(u2_cnt),  40'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        valid = 1'b0; prim = 1'b0; data = '0; clr = 1'b0;

        // Reset with a live input word
        step(1'b1, 1'b0, 32'h5555aaaa);
        exp_zero("reset");
        reset_n = 1'b1;

        // Expansion / dedup
        step(1'b1, 1'b1, W_XRDY);
        exp0("xrdy", 1'b1, 1'b1, W_XRDY, 5'd2);
        chk("dedup.xrdy.valid", 40'(u1_valid), 40'd1);
        chk("dedup.xrdy.id",    40'(u1_id),    40'd2);
        step(1'b1, 1'b1, W_CONT);
        exp0("cont", 1'b1, 1'b1, W_XRDY, 5'd2);
        chk("dedup.cont.valid", 40'(u1_valid), 40'd0);
        chk("lowpower.data",    40'(u1_data),  40'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'ha5a50000 + 32'(i));
            exp0("junk", 1'b1, 1'b1, W_XRDY, 5'd2);
            chk("junk.cnt", 40'(u0_cnt), 40'(i + 1));
            chk("dedup.junk.valid", 40'(u1_valid), 40'd0);
        end
        chk("lg2.cnt3", 40'(u2_cnt), 40'd3);
        step(1'b1, 1'b1, W_RRDY);
        exp0("rrdy", 1'b1, 1'b1, W_RRDY, 5'd3);
        chk("rrdy.cnt", 40'(u0_cnt), 40'd3);
        chk("dedup.rrdy.valid", 40'(u1_valid), 40'd1);
        chk("dedup.rrdy.id",    40'(u1_id),    40'd3);

        // ALIGN transparent inside a run
        step(1'b1, 1'b1, W_HOLD);
        exp0("hold", 1'b1, 1'b1, W_HOLD, 5'd6);
        step(1'b1, 1'b1, W_CONT);
        exp0("hold.cont", 1'b1, 1'b1, W_HOLD, 5'd6);
        step(1'b1, 1'b0, 32'h01020304);
        exp0("hold.junk1", 1'b1, 1'b1, W_HOLD, 5'd6);
        step(1'b1, 1'b1, W_ALIGN);
        exp0("align1", 1'b0, 1'b0, 32'd0, 5'd0);
        step(1'b1, 1'b1, W_ALIGN);
        exp0("align2", 1'b0, 1'b0, 32'd0, 5'd0);
        step(1'b1, 1'b0, 32'h05060708);
        exp0("hold.junk2", 1'b1, 1'b1, W_HOLD, 5'd6);
        chk("hold.cnt", 40'(u0_cnt), 40'd5);
        chk("lg2.sat",  40'(u2_cnt), 40'd3);

        // Clear beats increment
        step(1'b1, 1'b0, 32'h090a0b0c, 1'b1);
        chk("clr.u0cnt", 40'(u0_cnt), 40'd0);
        chk("clr.u2cnt", 40'(u2_cnt), 40'd0);
        exp0("clr.emit", 1'b1, 1'b1, W_HOLD, 5'd6);

        // Unknown primitive then pass-through
        step(1'b1, 1'b1, W_UNK);
        exp0("unk", 1'b1, 1'b1, W_UNK, 5'd0);
        chk("unk.err", 40'(u0_unk), 40'd1);
        step(1'b1, 1'b0, 32'h12345678);
        exp0("pass", 1'b1, 1'b0, 32'h12345678, 5'd0);
        chk("pass.unk", 40'(u0_unk), 40'd0);
        step(1'b0, 1'b0, 32'hdeadbeef);
        chk("idle.valid", 40'({u0_valid, u0_orph, u0_unk}), 40'd0);

        // Orphan CONT after reset
        reset_n = 1'b0;
        step(1'b1, 1'b1, W_CONT);
        exp_zero("reset2");
        reset_n = 1'b1;
        step(1'b1, 1'b1, W_CONT);
        exp0("orphan", 1'b0, 1'b0, 32'd0, 5'd0);
        chk("orphan.err", 40'(u0_orph), 40'd1);
        step(1'b1, 1'b0, 32'h11111111);
        exp0("orphan.d1", 1'b0, 1'b0, 32'd0, 5'd0);
        chk("orphan.err1", 40'(u0_orph), 40'd0);
        step(1'b1, 1'b0, 32'h22222222);
        exp0("orphan.d2", 1'b0, 1'b0, 32'd0, 5'd0);
        chk("orphan.cnt", 40'(u0_cnt), 40'd2);

        // Reset mid-run; first CONT afterwards is an orphan
        reset_n = 1'b0;
        step(1'b1, 1'b0, 32'h33333333);
        exp_zero("reset3");
        reset_n = 1'b1;
        step(1'b1, 1'b1, W_CONT);
        chk("orphan2.err", 40'(u0_orph), 40'd1);

        // Back-to-back CONTs and primitive right after CONT
        step(1'b1, 1'b1, W_SYNC);
        exp0("sync", 1'b1, 1'b1, W_SYNC, 5'd1);
        chk("dedup.sync.valid", 40'(u1_valid), 40'd1);
        step(1'b1, 1'b1, W_CONT);
        exp0("b2b.c1", 1'b1, 1'b1, W_SYNC, 5'd1);
        chk("dedup.b2b.c1", 40'(u1_valid), 40'd0);
        step(1'b1, 1'b1, W_CONT);
        exp0("b2b.c2", 1'b1, 1'b1, W_SYNC, 5'd1);
        chk("dedup.b2b.c2", 40'(u1_valid), 40'd0);
        chk("b2b.cnt", 40'(u0_cnt), 40'd0);
        step(1'b1, 1'b1, W_SYNC);
        exp0("sync2", 1'b1, 1'b1, W_SYNC, 5'd1);
        chk("dedup.sync2", 40'(u1_valid), 40'd0);
        step(1'b1, 1'b0, 32'hcafef00d);
        exp0("after.pass", 1'b1, 1'b0, 32'hcafef00d, 5'd0);
        chk("after.cnt", 40'(u0_cnt), 40'd0);
        chk("dedup.after.valid", 40'(u1_valid), 40'd1);
        chk("dedup.after.data",  40'(u1_data),  40'hcafef00d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
